gpo_sched: RTL

Timed output-event scheduler for the general-purpose output block. The CPU queues {delay, mask, set/clear} events through a memory-mapped slave port. The block drains the queue in order, waits each event's delay in clock cycles, then acts as bus master toward the GPO set/clear registers. It sits between the system bus and the GPO peripheral, giving software cycle-accurate output waveforms without polling.

---
 rtl/gpo_sched_if.sv | 21 ++
 rtl/gpo_sched.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gpo_sched_if.sv
// Bus bundle for gpo_sched: CPU-facing slave port and GPO-facing master port.
interface gpo_sched_if;
  logic        i_rd;
  logic        i_wr;
  logic [31:0] i_addr;
  logic [3:0]  i_wrmask;
  logic [31:0] i_data;
  logic        o_rd_valid;
  logic        o_wr_valid;
  logic [31:0] o_data;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_wrmask;
  logic        m_wr_valid;

  modport slave  (input i_rd, i_wr, i_addr, i_wrmask, i_data,
                  output o_rd_valid, o_wr_valid, o_data);
  modport master (output m_wr, m_addr, m_data, m_wrmask,
                  input m_wr_valid);
endinterface

// File: rtl/gpo_sched.sv
// Timed GPO event scheduler: CPU-fed event FIFO drained by a delay/issue/ack FSM
// that writes masks to the GPO set/clear registers.
module gpo_sched #(
  parameter logic [31:0] BASE       = 32'h4000_0100,
  parameter logic [31:0] SET_ADDR   = 32'h4000_0004,
  parameter logic [31:0] CLEAR_ADDR = 32'h4000_0008,
  parameter int          DEPTH      = 8,
  parameter int          CW         = 24,
  parameter int          TMO        = 15
) (
  input  logic         clk,
  input  logic         rst,
  gpo_sched_if.slave   s,
  gpo_sched_if.master  m
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int TW   = $clog2(TMO + 2);

  typedef struct packed {
    logic          op;    // 1 = clear
    logic [CW-1:0] dly;
    logic [31:0]   mask;
  } evt_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_ACK} state_t;

  state_t          r_state, w_next;
  evt_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CNTW-1:0] r_count;
  logic            r_en, r_ovf, r_tmo_f;
  logic [31:0]     r_dly;
  logic            r_op;
  logic [31:0]     r_mask;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_tmo;
  logic            r_rd_valid, r_wr_valid;
  logic [31:0]     r_rdata;

  logic [31:0] w_off, w_rdata;
  logic        w_hit, w_rd, w_wr, w_flush, w_push, w_push_ok, w_pop;
  logic        w_full, w_empty, w_busy, w_tmo_hit, w_unused;
  evt_t        w_new, w_head;

  assign w_off    = s.i_addr - BASE;
  assign w_hit    = (s.i_addr >= BASE) && (w_off < 32'h14);
  assign w_rd     = s.i_rd && w_hit;
  assign w_wr     = s.i_wr && w_hit;
  assign w_unused = ^s.i_wrmask;

  assign w_full    = (r_count == CNTW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_flush   = w_wr && (w_off == 32'h00) && s.i_data[1];
  // A push that coincides with FLUSH is discarded along with the queue.
  assign w_push    = w_wr && ((w_off == 32'h0C) || (w_off == 32'h10)) && !w_flush;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_new     = '{op: (w_off == 32'h10), dly: r_dly[CW-1:0], mask: s.i_data};
  assign w_head    = r_mem[r_rptr];
  assign w_tmo_hit = (r_state == S_ACK) && !m.m_wr_valid && (r_tmo == TW'(TMO));

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNTW'(w_push_ok) - CNTW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:  if (r_en && !w_empty && !w_flush) begin
                 w_pop  = 1'b1;
                 w_next = S_WAIT;
               end
      S_WAIT:  if (w_flush)           w_next = S_IDLE;
               else if (r_cnt == '0)  w_next = S_ISSUE;
      S_ISSUE: w_next = S_ACK;
      S_ACK:   if (m.m_wr_valid || w_tmo_hit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= 1'b0;
      r_mask <= '0;
      r_cnt  <= '0;
      r_tmo  <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_pop) begin
                   r_op   <= w_head.op;
                   r_mask <= w_head.mask;
                   r_cnt  <= w_head.dly;
                 end
        S_WAIT:  if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        S_ISSUE: r_tmo <= '0;
        S_ACK:   if (!m.m_wr_valid && !w_tmo_hit) r_tmo <= r_tmo + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      32'h00:  w_rdata = {31'b0, r_en};
      32'h04:  w_rdata = {19'b0, r_tmo_f, r_ovf, w_empty, w_full, w_busy, 8'(r_count)};
      32'h08:  w_rdata = r_dly;
      default: w_rdata = '0;
    endcase
  end

  // Sticky flags: a set event in the same cycle as a STATUS write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_dly      <= '0;
      r_ovf      <= 1'b0;
      r_tmo_f    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rd_valid <= w_rd;
      r_wr_valid <= w_wr;
      if (w_rd) r_rdata <= w_rdata;
      if (w_wr && w_off == 32'h00) r_en  <= s.i_data[0];
      if (w_wr && w_off == 32'h08) r_dly <= s.i_data;
      if (w_wr && w_off == 32'h04) begin
        r_ovf   <= 1'b0;
        r_tmo_f <= 1'b0;
      end
      if (w_push && w_full && !w_pop) r_ovf   <= 1'b1;
      if (w_tmo_hit)                  r_tmo_f <= 1'b1;
    end
  end

  assign s.o_rd_valid = r_rd_valid;
  assign s.o_wr_valid = r_wr_valid;
  assign s.o_data     = r_rdata;

  assign m.m_wr     = (r_state == S_ISSUE);
  assign m.m_addr   = m.m_wr ? (r_op ? CLEAR_ADDR : SET_ADDR) : '0;
  assign m.m_data   = m.m_wr ? r_mask : '0;
  assign m.m_wrmask = m.m_wr ? 4'hF : 4'h0;
endmodule
